// File: rtl/pipeline_if_stage_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, reset PC, NOP, and the
// opcode/ALU constants that the decode and execute stages also use.
package pipeline_if_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SLT = 4'h4;

  // Word-aligned branch displacement from a 16-bit immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_next_pc.sv
// Redirect target for the fetch stage: jr, j-type region jump, or PC-relative branch.
module pipeline_next_pc
  import pipeline_if_stage_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  input  logic        jump,
  input  logic        jump_rs,
  output logic [31:0] target
);

  always_comb begin
    target = pc_plus4 + branch_offset(instr_index[15:0]);
    if (jump_rs) begin
      target = rs_data;
    end else if (jump) begin
      target = {pc_plus4[31:28], instr_index, 2'b00};
    end
  end

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction fetch stage: drives the imem request, owns the IF/ID register,
// buffers one word across an ID stall and squashes fetches overtaken by a redirect.
//
//   state  | meaning
//   FETCH  | request at req_addr outstanding; IF/ID loads when it completes
//   HOLD   | ID stalled after a word arrived; word parked in hold_buf, no request
//   SQUASH | redirect hit an incomplete request; finish it, drop data, refetch at pc
module pipeline_if_stage
  import pipeline_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        shouldStall,
  input  logic        jump,
  input  logic        jumpRs,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] id_rs_data,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] hold_buf;
  logic [31:0] target;
  logic [31:0] addr_next;
  logic        redirect;

  // A stall means ID has not resolved its branch yet, so it wins over redirect.
  assign redirect  = shouldJumpOrBranch & ~shouldStall;
  assign addr_next = req_addr + 32'd4;
  assign imem_addr = req_addr;
  assign imem_req  = (state != ST_HOLD);

  pipeline_next_pc u_next_pc (
    .pc_plus4    (id_pc_plus4),
    .instr_index (id_instruction[25:0]),
    .rs_data     (id_rs_data),
    .jump        (jump),
    .jump_rs     (jumpRs),
    .target      (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_FETCH;
      pc             <= RESET_PC;
      req_addr       <= RESET_PC;
      hold_buf       <= NOP;
      id_instruction <= NOP;
      id_pc_plus4    <= RESET_PC;
      id_valid       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            id_instruction <= NOP;
            id_valid       <= 1'b0;
            pc             <= target;
            if (imem_ready) begin
              req_addr <= target;
            end else begin
              state <= ST_SQUASH;
            end
          end else if (shouldStall) begin
            if (imem_ready) begin
              hold_buf <= imem_rdata;
              pc       <= addr_next;
              state    <= ST_HOLD;
            end
          end else if (imem_ready) begin
            id_instruction <= imem_rdata;
            id_pc_plus4    <= addr_next;
            id_valid       <= 1'b1;
            pc             <= addr_next;
            req_addr       <= addr_next;
          end else begin
            // ID moved on but nothing arrived: present a bubble.
            id_instruction <= NOP;
            id_valid       <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            id_instruction <= NOP;
            id_valid       <= 1'b0;
            pc             <= target;
            req_addr       <= target;
            state          <= ST_FETCH;
          end else if (!shouldStall) begin
            // pc already equals the buffered word's address + 4.
            id_instruction <= hold_buf;
            id_pc_plus4    <= pc;
            id_valid       <= 1'b1;
            req_addr       <= pc;
            state          <= ST_FETCH;
          end
        end
        ST_SQUASH: begin
          if (imem_ready) begin
            req_addr <= pc;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed bench for pipeline_if_stage: hand sequences for reset, stall, latency
// and reset-during-squash, then a table of redirect/branch vectors.
module tb_pipeline_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        shouldStall;
  logic        jump;
  logic        jumpRs;
  logic        shouldJumpOrBranch;
  logic [31:0] id_rs_data;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  logic [31:0] sp_addr;
  logic [31:0] sp_word;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .imem_ready         (imem_ready),
    .shouldStall        (shouldStall),
    .jump               (jump),
    .jumpRs             (jumpRs),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .id_rs_data         (id_rs_data),
    .id_instruction     (id_instruction),
    .id_pc_plus4        (id_pc_plus4),
    .id_valid           (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Memory model: one programmable word, address-derived pattern elsewhere.
  always_comb begin
    imem_rdata = (imem_addr == sp_addr) ? sp_word : pat(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic sjb, input logic j, input logic jr, input logic st,
                     input logic [31:0] rs);
    shouldJumpOrBranch = sjb;
    jump               = j;
    jumpRs             = jr;
    shouldStall        = st;
    id_rs_data         = rs;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        j;
    logic        jr;
    logic        take;
    logic        stall;
    logic [31:0] rs;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0004, 1'b0, 32'h0000_0014};
    vecs[1] = '{32'h0000_0100, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0110, 1'b0, 32'h0000_0104};
    vecs[2] = '{32'h2000_0040, 32'h0800_0100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h2000_0400, 1'b0, 32'h2000_0044};
    vecs[3] = '{32'h0000_0080, 32'h0060_0008, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0000_0400, 1'b0, 32'h0000_0084};
    vecs[4] = '{32'h0000_0030, 32'h1000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0038, 1'b1, 32'h0000_0038};
    vecs[5] = '{32'h0000_0050, 32'h1000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0054, 1'b1, 32'h0000_0054};
    vecs[6] = '{32'hFFFF_FFF8, 32'h1000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC};
    vecs[7] = '{32'hFFFF_FFF8, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[8] = '{32'h0000_1000, 32'h1000_8000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFE_1004, 1'b0, 32'h0000_1004};
    vecs[9] = '{32'h0000_0200, 32'h0800_0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0204};

    sp_addr    = 32'hDEAD_BEE0;
    sp_word    = 32'h0;
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();

    // Reset values and free-running sequential fetch.
    rst_n = 1'b1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h1);
    chk("rst_instr", id_instruction, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_pc4", id_pc_plus4, 32'(4 * k));
      chk("seq_instr", id_instruction, pat(32'(4 * (k - 1))));
      chk("seq_valid", 32'(id_valid), 32'h1);
    end

    // Stall two cycles while the word from 0x20 returns.
    shouldStall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_addr", imem_addr, 32'h20);
      chk("stall_pc4", id_pc_plus4, 32'h20);
      chk("stall_instr", id_instruction, pat(32'h1C));
    end
    shouldStall = 1'b0;
    tick();
    chk("unstall_instr", id_instruction, pat(32'h20));
    chk("unstall_pc4", id_pc_plus4, 32'h24);
    chk("unstall_valid", 32'(id_valid), 32'h1);
    chk("unstall_addr", imem_addr, 32'h24);
    tick();
    chk("post_stall_addr", imem_addr, 32'h28);

    // jr to 0x400 while the 0x28 request waits three cycles for ready.
    imem_ready = 1'b0;
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h400);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sq_addr", imem_addr, 32'h28);
    chk("sq_req", 32'(imem_req), 32'h1);
    chk("sq_valid", 32'(id_valid), 32'h0);
    chk("sq_instr", id_instruction, 32'h0);
    chk("sq_pc4", id_pc_plus4, 32'h28);
    tick();
    chk("sq_wait_addr", imem_addr, 32'h28);
    imem_ready = 1'b1;
    tick();
    chk("sq_done_addr", imem_addr, 32'h400);
    chk("sq_done_valid", 32'(id_valid), 32'h0);
    tick();
    chk("jr_instr", id_instruction, pat(32'h400));
    chk("jr_pc4", id_pc_plus4, 32'h404);
    chk("jr_addr", imem_addr, 32'h404);

    // Stall while ready is low keeps the request and IF/ID.
    imem_ready  = 1'b0;
    shouldStall = 1'b1;
    tick();
    chk("stall_wait_addr", imem_addr, 32'h404);
    chk("stall_wait_instr", id_instruction, pat(32'h400));
    shouldStall = 1'b0;

    // Asynchronous reset in the middle of SQUASH.
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h800);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_addr", imem_addr, 32'h404);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_instr", id_instruction, 32'h0);
    chk("arst_pc4", id_pc_plus4, 32'h0);
    chk("arst_valid", 32'(id_valid), 32'h0);
    #1 rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    chk("restart_addr", imem_addr, 32'h4);
    chk("restart_instr", id_instruction, pat(32'h0));

    // Redirect vectors: jr to the vector address, fetch it, then apply ID controls.
    for (int i = 0; i < 10; i++) begin
      sp_addr = vecs[i].addr;
      sp_word = vecs[i].instr;
      ctl(1'b1, 1'b0, 1'b1, 1'b0, vecs[i].addr);
      tick();
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      ctl(vecs[i].take, vecs[i].j, vecs[i].jr, vecs[i].stall, vecs[i].rs);
      tick();
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc4", i), id_pc_plus4, vecs[i].exp_pc4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_if_stage.md
PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch address; held stable while imem_req=1 and imem_ready=0.
REQ-006 SHALL have port imem_rdata  input  32  fetched word; valid when imem_ready=1.
REQ-007 SHALL have port imem_ready  input  1  completes current request; may rise in the request cycle or any later cycle.
REQ-008 SHALL have port shouldStall  input  1  ID data-hazard stall; freezes IF/ID and PC.
REQ-009 SHALL have ports jump, jumpRs, shouldJumpOrBranch  input  1 each  ID redirect controls.
REQ-010 SHALL have port id_rs_data  input  32  forwarded rs value, the jr target.
REQ-011 SHALL have port id_instruction  output  32  IF/ID instruction register, drives ID control.
REQ-012 SHALL have port id_pc_plus4  output  32  IF/ID PC+4 register.
REQ-013 SHALL have port id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-014 SHALL implement states FETCH, HOLD, SQUASH; imem_req=1 in FETCH and SQUASH, 0 in HOLD.
REQ-015 SHALL keep pc (next fetch) and req_addr (address in flight); imem_addr=req_addr.
REQ-016 FETCH, imem_ready=1, redirect=0, shouldStall=0: SHALL load IF/ID with {imem_rdata, req_addr+4, valid=1}, set pc and req_addr to req_addr+4, stay FETCH.
REQ-017 FETCH, imem_ready=1, shouldStall=1: SHALL capture imem_rdata into a one-entry buffer, advance pc, hold IF/ID, go HOLD.
REQ-018 FETCH, imem_ready=0, shouldStall=1: SHALL hold IF/ID, keep request pending, stay FETCH.
REQ-019 HOLD, shouldStall=0, no redirect: SHALL load IF/ID from buffer (valid=1), go FETCH with req_addr=pc.
REQ-020 Redirect is shouldJumpOrBranch=1 with shouldStall=0; shouldStall=1 SHALL override redirect (ID re-evaluates after stall).
REQ-021 Redirect target SHALL be: jumpRs -> id_rs_data; jump -> {id_pc_plus4[31:28], id_instruction[25:0], 2'b00}; else -> id_pc_plus4 + (sign-extended id_instruction[15:0] << 2), modulo 2^32.
REQ-022 On redirect SHALL load IF/ID with bubble {32'h0, id_pc_plus4 unchanged, valid=0} and set pc=target; there is no delay slot.
REQ-023 Redirect in FETCH with imem_ready=1 SHALL discard rdata, set req_addr=target, stay FETCH.
REQ-024 Redirect in FETCH with imem_ready=0 SHALL keep req_addr, go SQUASH; SQUASH on imem_ready=1 discards rdata, sets req_addr=pc, goes FETCH.
REQ-025 Redirect in HOLD SHALL discard buffer, set req_addr=target, go FETCH.
REQ-026 SQUASH SHALL ignore shouldStall for its own transition; IF/ID holds bubble until FETCH delivers.
REQ-027 PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Reset
REQ-028 rst_n=0 SHALL immediately set state=FETCH, pc=req_addr=RESET_PC, id_instruction=0, id_pc_plus4=RESET_PC, id_valid=0, buffer=0.
REQ-029 Reset mid-request SHALL abandon the request; memory side tolerates a dropped req.
REQ-030 First imem_req SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.

Structure
REQ-031 State encoding, RESET_PC default and NOP constant (32'h0) SHALL live in the shared CPU package with the ALU/opcode constants.
REQ-032 Target computation SHALL be one combinational sub-module, pipeline_next_pc.

Verification
REQ-033 Reset release, imem_ready tied 1, stall 0 -> addresses 0,4,8,... one per cycle; id_pc_plus4 = addr+4, id_valid=1 from second cycle.
REQ-034 beq at 0x10, imm=16'hFFFC, taken -> next imem_addr 0x04, IF/ID shows 0x0/valid=0 one cycle.
REQ-035 shouldStall=1 two cycles while word from 0x20 returns -> state HOLD, IF/ID unchanged; on release IF/ID = word@0x20, next fetch 0x24.
REQ-036 imem_ready 3-cycle latency, jr to 0x400 during wait -> old address held until ready, data discarded, then imem_addr=0x400.
REQ-037 shouldStall=1 and shouldJumpOrBranch=1 same cycle -> no redirect, PC and IF/ID frozen.
REQ-038 rst_n low mid-SQUASH -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.
